// File: rtl/f2m_mul_if.sv
// Request/response bundle for the GF(2^M) multiplier.
// Carries the clear/start controls, the operands and the result.
interface f2m_mul_if #(
    parameter int M = 163
);
    logic         clr;
    logic         start;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic         done;
    logic [M-1:0] z;

    modport master (
        output clr,
        output start,
        output a,
        output b,
        input  done,
        input  z
    );

    modport slave (
        input  clr,
        input  start,
        input  a,
        input  b,
        output done,
        output z
    );
endinterface

// File: rtl/f2m_mul.sv
// Bit-serial MSB-first GF(2^M) multiplier, one bit of b per clock.
// Optional busy output under macro F2M_MUL_BUSY_EN.
module f2m_mul #(
    parameter int           M  = 163,
    parameter logic [M-1:0] FX = 163'hc9
) (
    input  logic clk,
    input  logic rst_n,
`ifdef F2M_MUL_BUSY_EN
    output logic busy,
`endif
    f2m_mul_if.slave bus
);
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0] cnt;
    logic [M-1:0]  acc;
    logic [M-1:0]  aq;
    logic [M-1:0]  bq;
    logic [M-1:0]  acc_x;
    logic [M-1:0]  acc_nx;
    logic          run;
    logic          last;

    assign run  = (state == S_RUN);
    assign last = (cnt == LAST);

    // acc*x mod f, then conditionally add a for the current b bit
    always_comb begin
        acc_x = {acc[M-2:0], 1'b0};
        if (acc[M-1]) begin
            acc_x = acc_x ^ FX;
        end
        acc_nx = acc_x;
        if (bq[M-1]) begin
            acc_nx = acc_x ^ aq;
        end
    end

    always_comb begin
        state_nx = state;
        if (bus.clr) begin
            state_nx = S_IDLE;
        end else if (bus.start) begin
            state_nx = S_RUN;
        end else if (run && last) begin
            state_nx = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
        end else if (bus.clr) begin
            cnt <= '0;
        end else if (bus.start) begin
            cnt <= '0;
            acc <= '0;
        end else if (run) begin
            acc <= acc_nx;
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    // Operand registers carry no reset; b shifts so its MSB is the live bit
    always_ff @(posedge clk) begin
        if (!bus.clr && bus.start) begin
            aq <= bus.a;
            bq <= bus.b;
        end else if (run) begin
            bq <= {bq[M-2:0], 1'b0};
        end
    end

    assign bus.done = (state == S_DONE);
    assign bus.z    = acc;

`ifdef F2M_MUL_BUSY_EN
    assign busy = run;
`endif
endmodule

// File: tb/tb_f2m_mul.sv
// Directed and model-checked bench for f2m_mul at M=163, FX=c9.
// Also checks busy timing when F2M_MUL_BUSY_EN is defined.
module tb_f2m_mul;
    localparam int M = 163;
    localparam logic [M-1:0] FX = 163'hc9;

    logic clk;
    logic rst_n;
    logic busy;
    int   checks;
    int   errors;

    f2m_mul_if #(.M(M)) bus ();

    f2m_mul #(.M(M), .FX(FX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef F2M_MUL_BUSY_EN
        .busy  (busy),
`endif
        .bus   (bus)
    );

`ifndef F2M_MUL_BUSY_EN
    assign busy = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [M-1:0] obs,
                         input logic [M-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [M-1:0] mulx(input logic [M-1:0] t);
        logic [M-1:0] r;
        r = {t[M-2:0], 1'b0};
        if (t[M-1]) r = r ^ FX;
        return r;
    endfunction

    // LSB-first reference: sum of b[i] * (a * x^i mod f)
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                            input logic [M-1:0] b);
        logic [M-1:0] r;
        logic [M-1:0] t;
        r = '0;
        t = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ t;
            t = mulx(t);
        end
        return r;
    endfunction

    function automatic logic [M-1:0] rnd();
        logic [191:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[M-1:0];
    endfunction

    task automatic start_op(input logic [M-1:0] a, input logic [M-1:0] b);
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
    endtask

    // Called just after the start edge; lat counts edges including it
    task automatic wait_done(output int lat, output int busy_cyc);
        lat = 1;
        busy_cyc = 0;
        while (!bus.done && lat < 400) begin
            if (busy) busy_cyc++;
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input string tag,
                           input logic [M-1:0] a,
                           input logic [M-1:0] b,
                           input logic [M-1:0] exp);
        int lat;
        int bc;
        start_op(a, b);
        wait_done(lat, bc);
        check({tag, "_lat"}, M'(lat), M'(164));
        check({tag, "_z"}, bus.z, exp);
`ifdef F2M_MUL_BUSY_EN
        check({tag, "_busy_cyc"}, M'(bc), M'(163));
        check({tag, "_busy_end"}, M'(busy), M'(0));
`endif
    endtask

    task automatic watch_no_done(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.done) seen++;
            tick();
        end
        check(tag, M'(seen), M'(0));
    endtask

    logic [M-1:0] ra;
    logic [M-1:0] rb;
    logic [M-1:0] ones;
    int lat;
    int bc;

    initial begin
        checks = 0;
        errors = 0;
        ones = '1;
        rst_n = 1'b0;
        bus.clr = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) tick();
        check("rst_done", M'(bus.done), M'(0));
        check("rst_z", bus.z, '0);
        check("rst_busy", M'(busy), M'(0));
        rst_n = 1'b1;
        tick();

        run_vec("a1_b2", 163'h1, 163'h2, 163'h2);
        repeat (5) tick();
        check("hold_done", M'(bus.done), M'(1));
        check("hold_z", bus.z, 163'h2);

        run_vec("reduce", 163'h1 << 162, 163'h2, 163'hc9);
        run_vec("inverse", 163'h2, (163'h1 << 162) | 163'h64, 163'h1);
        run_vec("zero", 163'h0, ones, 163'h0);

        start_op(163'h1, 163'h1);
        check("rerun_done_low", M'(bus.done), M'(0));
        wait_done(lat, bc);
        check("rerun_lat", M'(lat), M'(164));
        check("rerun_z", bus.z, 163'h1);

        run_vec("x1_sq", 163'h3, 163'h3, 163'h5);

        // Restart mid-run
        start_op(163'h1, 163'h2);
        repeat (49) tick();
        start_op(163'h1, 163'h1);
        check("restart_done_low", M'(bus.done), M'(0));
        wait_done(lat, bc);
        check("restart_lat", M'(lat), M'(164));
        check("restart_z", bus.z, 163'h1);

        // Clear mid-run
        start_op(163'h1, 163'h2);
        repeat (49) tick();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        check("clr_busy", M'(busy), M'(0));
        watch_no_done("clr_no_done", 200);

        // Clear wins over a simultaneous start, and drops a held done
        run_vec("pre_clr", 163'h1, 163'h2, 163'h2);
        bus.clr = 1'b1;
        bus.start = 1'b1;
        bus.a = 163'h1;
        bus.b = 163'h1;
        tick();
        bus.clr = 1'b0;
        bus.start = 1'b0;
        check("clrstart_done", M'(bus.done), M'(0));
        check("clrstart_busy", M'(busy), M'(0));
        watch_no_done("clrstart_no_done", 200);

        // Reset mid-run
        start_op(163'h1, 163'h2);
        repeat (49) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_done", M'(bus.done), M'(0));
        check("midrst_busy", M'(busy), M'(0));
        check("midrst_z", bus.z, '0);
        watch_no_done("midrst_no_done", 200);

        for (int i = 0; i < 40; i++) begin
            ra = rnd();
            rb = rnd();
            run_vec($sformatf("rand%0d", i), ra, rb, gf_mul(ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
